// File: rtl/mpdmac_axi_pkg.sv
// Shared AXI3 encodings, FSM state types and request-qualification helpers
// for the DMA-side AXI memory slave.
package mpdmac_axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] SIZE_4B     = 3'b010;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

  // Only full-word FIXED and INCR bursts are served; anything else errors every beat.
  function automatic logic ctl_ok(input logic [1:0] burst, input logic [2:0] size);
    return ((burst == BURST_FIXED) || (burst == BURST_INCR)) && (size == SIZE_4B);
  endfunction

  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [1:0] burst);
    return (burst == BURST_INCR) ? (addr + 32'd4) : addr;
  endfunction

endpackage

// File: rtl/mpdmac_axi_mem_array.sv
// 1W1R word SRAM with per-byte write enables and a registered read port.
// A same-edge write and read of one word returns the old contents.
module mpdmac_axi_mem_array
  import mpdmac_axi_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [3:0]    wbe_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [0:(1<<AW)-1];
  logic [31:0] rdata_q;

  // Storage and read register; read output only moves on a fetch so stalled beats hold.
  always_ff @(posedge clk) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
    for (int b = 0; b < 4; b++) begin
      if (we_i && wbe_i[b]) begin
        mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mpdmac_axi_mem_slave.sv
// AXI3 slave memory responder: independent write and read FSMs over a 1W1R SRAM,
// one outstanding burst per direction, unsupported requests answered with SLVERR.
module mpdmac_axi_mem_slave
  import mpdmac_axi_pkg::*;
#(
  parameter int          MEM_AW    = 12,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  awid_i,
  input  logic [31:0] awaddr_i,
  input  logic [3:0]  awlen_i,
  input  logic [2:0]  awsize_i,
  input  logic [1:0]  awburst_i,
  input  logic        awvalid_i,
  output logic        awready_o,
  input  logic [3:0]  wid_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  input  logic        wlast_i,
  input  logic        wvalid_i,
  output logic        wready_o,
  output logic [3:0]  bid_o,
  output logic [1:0]  bresp_o,
  output logic        bvalid_o,
  input  logic        bready_i,
  input  logic [3:0]  arid_i,
  input  logic [31:0] araddr_i,
  input  logic [3:0]  arlen_i,
  input  logic [2:0]  arsize_i,
  input  logic [1:0]  arburst_i,
  input  logic        arvalid_i,
  output logic        arready_o,
  output logic [3:0]  rid_o,
  output logic [31:0] rdata_o,
  output logic [1:0]  rresp_o,
  output logic        rlast_o,
  output logic        rvalid_o,
  input  logic        rready_i
);

  wr_state_e   w_state_q, w_state_d;
  logic [3:0]  awid_q, awid_d, awlen_q, awlen_d, wcnt_q, wcnt_d;
  logic [31:0] waddr_q, waddr_d;
  logic [1:0]  wburst_q, wburst_d;
  logic        wctl_ok_q, wctl_ok_d, werr_q, werr_d;
  logic        wbeat_err_s, mem_we_s;

  rd_state_e   r_state_q, r_state_d;
  logic [3:0]  arid_q, arid_d, arlen_q, arlen_d, rcnt_q, rcnt_d;
  logic [31:0] raddr_q, raddr_d, rnext_s;
  logic [1:0]  rburst_q, rburst_d;
  logic        rctl_ok_q, rctl_ok_d, rerr_q, rerr_d, rlast_q, rlast_d;
  logic              mem_re_s;
  logic [MEM_AW-1:0] mem_raddr_s;
  logic [31:0]       mem_rdata_s;

  // Subtracting first keeps the upper-bound test free of 32-bit overflow.
  function automatic logic in_range(input logic [31:0] addr);
    return (addr >= BASE_ADDR) && (((addr - BASE_ADDR) >> (MEM_AW + 2)) == 32'd0);
  endfunction

  function automatic logic [MEM_AW-1:0] word_idx(input logic [31:0] addr);
    return MEM_AW'((addr - BASE_ADDR) >> 2);
  endfunction

  // Write FSM: address latch, beat acceptance with per-beat checks, response hold.
  always_comb begin
    w_state_d   = w_state_q;
    awid_d      = awid_q;
    awlen_d     = awlen_q;
    waddr_d     = waddr_q;
    wburst_d    = wburst_q;
    wctl_ok_d   = wctl_ok_q;
    wcnt_d      = wcnt_q;
    werr_d      = werr_q;
    wbeat_err_s = 1'b0;
    mem_we_s    = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (awvalid_i) begin
          awid_d    = awid_i;
          awlen_d   = awlen_i;
          waddr_d   = awaddr_i;
          wburst_d  = awburst_i;
          wctl_ok_d = ctl_ok(awburst_i, awsize_i);
          wcnt_d    = 4'd0;
          werr_d    = 1'b0;
          w_state_d = W_DATA;
        end else begin
          w_state_d = W_IDLE;
        end
      end
      W_DATA: begin
        if (wvalid_i) begin
          // Burst length is fixed by awlen; wlast only serves as a consistency check.
          wbeat_err_s = !wctl_ok_q || !in_range(waddr_q) || (wid_i != awid_q) ||
                        (wlast_i != (wcnt_q == awlen_q));
          mem_we_s    = !wbeat_err_s;
          werr_d      = werr_q | wbeat_err_s;
          waddr_d     = next_addr(waddr_q, wburst_q);
          wcnt_d      = wcnt_q + 4'd1;
          w_state_d   = (wcnt_q == awlen_q) ? W_RESP : W_DATA;
        end else begin
          w_state_d = W_DATA;
        end
      end
      W_RESP: begin
        if (bready_i) begin
          w_state_d = W_IDLE;
        end else begin
          w_state_d = W_RESP;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read FSM: each fetch is issued on the edge that retires the previous beat.
  always_comb begin
    r_state_d   = r_state_q;
    arid_d      = arid_q;
    arlen_d     = arlen_q;
    raddr_d     = raddr_q;
    rburst_d    = rburst_q;
    rctl_ok_d   = rctl_ok_q;
    rcnt_d      = rcnt_q;
    rerr_d      = rerr_q;
    rlast_d     = rlast_q;
    rnext_s     = next_addr(raddr_q, rburst_q);
    mem_re_s    = 1'b0;
    mem_raddr_s = word_idx(araddr_i);
    case (r_state_q)
      R_IDLE: begin
        if (arvalid_i) begin
          arid_d    = arid_i;
          arlen_d   = arlen_i;
          raddr_d   = araddr_i;
          rburst_d  = arburst_i;
          rctl_ok_d = ctl_ok(arburst_i, arsize_i);
          rcnt_d    = 4'd0;
          rerr_d    = !ctl_ok(arburst_i, arsize_i) || !in_range(araddr_i);
          rlast_d   = (arlen_i == 4'd0);
          mem_re_s  = 1'b1;
          r_state_d = R_DATA;
        end else begin
          r_state_d = R_IDLE;
        end
      end
      R_DATA: begin
        if (rready_i && (rcnt_q == arlen_q)) begin
          rerr_d    = 1'b0;
          rlast_d   = 1'b0;
          r_state_d = R_IDLE;
        end else if (rready_i) begin
          raddr_d     = rnext_s;
          rcnt_d      = rcnt_q + 4'd1;
          rerr_d      = !rctl_ok_q || !in_range(rnext_s);
          rlast_d     = ((rcnt_q + 4'd1) == arlen_q);
          mem_re_s    = 1'b1;
          mem_raddr_s = word_idx(rnext_s);
          r_state_d   = R_DATA;
        end else begin
          r_state_d = R_DATA;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // State and context registers for both channels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      awid_q    <= 4'd0;
      awlen_q   <= 4'd0;
      waddr_q   <= 32'd0;
      wburst_q  <= 2'd0;
      wctl_ok_q <= 1'b0;
      wcnt_q    <= 4'd0;
      werr_q    <= 1'b0;
      r_state_q <= R_IDLE;
      arid_q    <= 4'd0;
      arlen_q   <= 4'd0;
      raddr_q   <= 32'd0;
      rburst_q  <= 2'd0;
      rctl_ok_q <= 1'b0;
      rcnt_q    <= 4'd0;
      rerr_q    <= 1'b0;
      rlast_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      awid_q    <= awid_d;
      awlen_q   <= awlen_d;
      waddr_q   <= waddr_d;
      wburst_q  <= wburst_d;
      wctl_ok_q <= wctl_ok_d;
      wcnt_q    <= wcnt_d;
      werr_q    <= werr_d;
      r_state_q <= r_state_d;
      arid_q    <= arid_d;
      arlen_q   <= arlen_d;
      raddr_q   <= raddr_d;
      rburst_q  <= rburst_d;
      rctl_ok_q <= rctl_ok_d;
      rcnt_q    <= rcnt_d;
      rerr_q    <= rerr_d;
      rlast_q   <= rlast_d;
    end
  end

  mpdmac_axi_mem_array #(.AW(MEM_AW)) u_mem (
    .clk     (clk),
    .we_i    (mem_we_s),
    .waddr_i (word_idx(waddr_q)),
    .wdata_i (wdata_i),
    .wbe_i   (wstrb_i),
    .re_i    (mem_re_s),
    .raddr_i (mem_raddr_s),
    .rdata_o (mem_rdata_s)
  );

  assign awready_o = (w_state_q == W_IDLE);
  assign wready_o  = (w_state_q == W_DATA);
  assign bvalid_o  = (w_state_q == W_RESP);
  assign bid_o     = awid_q;
  assign bresp_o   = werr_q ? RESP_SLVERR : RESP_OKAY;
  assign arready_o = (r_state_q == R_IDLE);
  assign rvalid_o  = (r_state_q == R_DATA);
  assign rid_o     = arid_q;
  assign rresp_o   = rerr_q ? RESP_SLVERR : RESP_OKAY;
  assign rlast_o   = rlast_q;
  assign rdata_o   = ((r_state_q == R_DATA) && !rerr_q) ? mem_rdata_s : 32'h0000_0000;

endmodule

// File: tb/tb_mpdmac_axi_mem_slave.sv
// Directed bench for mpdmac_axi_mem_slave: a transaction-level memory model
// predicts every R/B beat and ready level, plus literal checks on captured data.
module tb_mpdmac_axi_mem_slave;

  localparam int          MEM_AW = 12;
  localparam int          DEPTH  = 1 << MEM_AW;
  localparam logic [31:0] BASE   = 32'h1000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] awid_i = 4'd0, awlen_i = 4'd0, wid_i = 4'd0, wstrb_i = 4'd0;
  logic [3:0] arid_i = 4'd0, arlen_i = 4'd0;
  logic [31:0] awaddr_i = 32'd0, wdata_i = 32'd0, araddr_i = 32'd0;
  logic [2:0] awsize_i = 3'd0, arsize_i = 3'd0;
  logic [1:0] awburst_i = 2'd0, arburst_i = 2'd0;
  logic awvalid_i = 1'b0, wlast_i = 1'b0, wvalid_i = 1'b0, bready_i = 1'b0;
  logic arvalid_i = 1'b0, rready_i = 1'b0;
  logic awready_o, wready_o, bvalid_o, arready_o, rlast_o, rvalid_o;
  logic [3:0] bid_o, rid_o;
  logic [1:0] bresp_o, rresp_o;
  logic [31:0] rdata_o;

  always #5 clk = ~clk;

  mpdmac_axi_mem_slave #(.MEM_AW(MEM_AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n),
    .awid_i(awid_i), .awaddr_i(awaddr_i), .awlen_i(awlen_i), .awsize_i(awsize_i),
    .awburst_i(awburst_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
    .wid_i(wid_i), .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wlast_i(wlast_i),
    .wvalid_i(wvalid_i), .wready_o(wready_o),
    .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
    .arid_i(arid_i), .araddr_i(araddr_i), .arlen_i(arlen_i), .arsize_i(arsize_i),
    .arburst_i(arburst_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
    .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o), .rlast_o(rlast_o),
    .rvalid_o(rvalid_o), .rready_i(rready_i)
  );

  typedef struct packed {logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last;} rbeat_t;
  typedef struct packed {logic [3:0] id; logic [1:0] resp;} bbeat_t;

  rbeat_t exp_r[$];
  bbeat_t exp_b[$];
  logic [31:0] mem_m [0:DEPTH-1];
  bit          w_active = 1'b0, w_err = 1'b0, werr_b;
  logic [3:0]  w_id, w_len, w_beat;
  logic [31:0] w_addr, ma;
  logic [1:0]  w_burst;
  logic [2:0]  w_size;
  rbeat_t      rb;
  bbeat_t      bb;
  int checks = 0, errors = 0;
  bit chk_en = 1'b0;

  logic [31:0] cap_d [0:15];
  logic        cap_l [0:15];
  logic [1:0]  cap_r [0:15];
  logic [3:0]  cap_id, cap_bid;
  logic [1:0]  cap_b;

  function automatic bit addr_ok(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'(4 * DEPTH));
  endfunction

  function automatic bit req_ok(input logic [1:0] burst, input logic [2:0] size);
    return ((burst == 2'b00) || (burst == 2'b01)) && (size == 3'b010);
  endfunction

  function automatic int idx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: memory image and expected beats, updated from observed handshakes.
  always @(posedge clk) begin
    if (rst_n) begin
      if (arvalid_i && arready_o) begin
        for (int i = 0; i <= int'(arlen_i); i++) begin
          ma = araddr_i + ((arburst_i == 2'b01) ? 32'(4 * i) : 32'd0);
          rb.id = arid_i;
          rb.last = (i == int'(arlen_i));
          if (req_ok(arburst_i, arsize_i) && addr_ok(ma)) begin
            rb.data = mem_m[idx(ma)];
            rb.resp = 2'b00;
          end else begin
            rb.data = 32'd0;
            rb.resp = 2'b10;
          end
          exp_r.push_back(rb);
        end
      end
      if (rvalid_o && rready_i && exp_r.size() != 0) void'(exp_r.pop_front());
      if (bvalid_o && bready_i && exp_b.size() != 0) void'(exp_b.pop_front());
      if (wvalid_i && wready_o && w_active) begin
        ma = w_addr + ((w_burst == 2'b01) ? {26'd0, w_beat, 2'b00} : 32'd0);
        werr_b = !req_ok(w_burst, w_size) || !addr_ok(ma) || (wid_i != w_id) ||
                 (wlast_i != (w_beat == w_len));
        if (!werr_b)
          for (int k = 0; k < 4; k++)
            if (wstrb_i[k]) mem_m[idx(ma)][8*k +: 8] = wdata_i[8*k +: 8];
        w_err = w_err | werr_b;
        if (w_beat == w_len) begin
          bb.id = w_id;
          bb.resp = w_err ? 2'b10 : 2'b00;
          exp_b.push_back(bb);
          w_active = 1'b0;
        end
        w_beat = w_beat + 4'd1;
      end
      if (awvalid_i && awready_o) begin
        w_active = 1'b1; w_err = 1'b0; w_beat = 4'd0;
        w_id = awid_i; w_len = awlen_i; w_addr = awaddr_i; w_burst = awburst_i; w_size = awsize_i;
      end
    end
  end

  // Compare process: every cycle, levels and beat contents against the model.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check("rvalid", 64'(rvalid_o), 64'(exp_r.size() != 0));
      if (rvalid_o && exp_r.size() != 0)
        check("rbeat", 64'({rid_o, rdata_o, rresp_o, rlast_o}), 64'(exp_r[0]));
      check("bvalid", 64'(bvalid_o), 64'(exp_b.size() != 0));
      if (bvalid_o && exp_b.size() != 0)
        check("bbeat", 64'({bid_o, bresp_o}), 64'(exp_b[0]));
      check("arready", 64'(arready_o), 64'(exp_r.size() == 0));
      check("awready", 64'(awready_o), 64'(!w_active && exp_b.size() == 0));
      check("wready", 64'(wready_o), 64'(w_active));
    end
  end

  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [1:0] burst, input logic [2:0] size);
    int n = 0;
    awid_i = id; awaddr_i = addr; awlen_i = len; awburst_i = burst; awsize_i = size; awvalid_i = 1'b1;
    do begin @(negedge clk); n++; end while (!awready_o && n < 100);
    if (!awready_o) check("aw_timeout", 64'(awready_o), 64'd1);
    @(posedge clk); #1; awvalid_i = 1'b0;
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [1:0] burst, input logic [2:0] size);
    int n = 0;
    arid_i = id; araddr_i = addr; arlen_i = len; arburst_i = burst; arsize_i = size; arvalid_i = 1'b1;
    do begin @(negedge clk); n++; end while (!arready_o && n < 100);
    if (!arready_o) check("ar_timeout", 64'(arready_o), 64'd1);
    @(posedge clk); #1; arvalid_i = 1'b0;
  endtask

  task automatic send_w(input logic [3:0] id, input logic [31:0] data, input logic [3:0] strb,
                        input logic last);
    int n = 0;
    wid_i = id; wdata_i = data; wstrb_i = strb; wlast_i = last; wvalid_i = 1'b1;
    do begin @(negedge clk); n++; end while (!wready_o && n < 100);
    if (!wready_o) check("w_timeout", 64'(wready_o), 64'd1);
    @(posedge clk); #1; wvalid_i = 1'b0;
  endtask

  task automatic get_b(input int hold);
    int n = 0;
    bready_i = 1'b0;
    do begin @(negedge clk); n++; end while (!bvalid_o && n < 100);
    if (!bvalid_o) check("b_timeout", 64'(bvalid_o), 64'd1);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1; @(negedge clk);
      check("b_hold", 64'(bvalid_o), 64'd1);
    end
    @(posedge clk); #1; bready_i = 1'b1;
    @(negedge clk); cap_b = bresp_o; cap_bid = bid_o;
    @(posedge clk); #1; bready_i = 1'b0;
  endtask

  task automatic rd_collect(input int nbeats, input bit toggle);
    int got = 0, cyc = 0;
    rready_i = 1'b1;
    while (got < nbeats && cyc < 200) begin
      @(negedge clk);
      if (rvalid_o && rready_i) begin
        cap_d[got] = rdata_o; cap_l[got] = rlast_o; cap_r[got] = rresp_o; cap_id = rid_o; got++;
      end
      @(posedge clk); #1; cyc++;
      rready_i = toggle ? ~rready_i : 1'b1;
    end
    rready_i = 1'b0;
    if (got < nbeats) check("r_timeout", 64'(got), 64'(nbeats));
  endtask

  task automatic wr1(input logic [3:0] id, input logic [31:0] addr, input logic [31:0] data,
                     input logic [3:0] strb);
    send_aw(id, addr, 4'd0, 2'b01, 3'b010);
    send_w(id, data, strb, 1'b1);
    get_b(0);
  endtask

  task automatic rd1(input logic [3:0] id, input logic [31:0] addr);
    send_ar(id, addr, 4'd0, 2'b01, 3'b010);
    rd_collect(1, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'd0;
    #12;
    check("rst_awready", 64'(awready_o), 64'd1);
    check("rst_arready", 64'(arready_o), 64'd1);
    check("rst_others", 64'({wready_o, bvalid_o, bid_o, bresp_o, rvalid_o, rid_o, rresp_o, rlast_o}), 64'd0);
    check("rst_rdata", 64'(rdata_o), 64'd0);
    @(posedge clk); #1; rst_n = 1'b1; chk_en = 1'b1;

    // single write then read
    wr1(4'd3, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF);
    check("single_bresp", 64'({cap_bid, cap_b}), 64'({4'd3, 2'b00}));
    check("model_pin_single", 64'(mem_m[4]), 64'h0000_0000_DEAD_BEEF);
    rd1(4'd5, BASE + 32'h10);
    check("single_rdata", 64'({cap_id, cap_d[0], cap_r[0], cap_l[0]}), 64'({4'd5, 32'hDEAD_BEEF, 2'b00, 1'b1}));

    // INCR burst with a stalling reader
    send_aw(4'd1, BASE + 32'h20, 4'd3, 2'b01, 3'b010);
    for (int k = 0; k < 4; k++) send_w(4'd1, 32'(k + 1), 4'hF, k == 3);
    get_b(0);
    check("incr_bresp", 64'(cap_b), 64'd0);
    send_ar(4'd2, BASE + 32'h20, 4'd3, 2'b01, 3'b010);
    rd_collect(4, 1'b1);
    for (int k = 0; k < 4; k++)
      check("incr_rdata", 64'({cap_d[k], cap_l[k]}), 64'({32'(k + 1), (k == 3)}));

    // FIXED read repeats one word
    send_ar(4'd4, BASE + 32'h24, 4'd2, 2'b00, 3'b010);
    rd_collect(3, 1'b0);
    check("fixed_rdata", 64'(cap_d[2]), 64'd2);

    // partial strobe
    wr1(4'd0, BASE + 32'h40, 32'h1122_3344, 4'hF);
    wr1(4'd0, BASE + 32'h40, 32'hAABB_CCDD, 4'b0101);
    check("model_pin_strobe", 64'(mem_m[16]), 64'h0000_0000_11BB_33DD);
    rd1(4'd0, BASE + 32'h40);
    check("strobe_rdata", 64'(cap_d[0]), 64'h0000_0000_11BB_33DD);

    // write errors: WRAP, out of range, wrong size, wrong wid, early wlast
    send_aw(4'd2, BASE + 32'h40, 4'd0, 2'b10, 3'b010); send_w(4'd2, 32'hFFFF_FFFF, 4'hF, 1'b1); get_b(0);
    check("wrap_bresp", 64'(cap_b), 64'd2);
    send_aw(4'd2, BASE + 32'h4000, 4'd0, 2'b01, 3'b010); send_w(4'd2, 32'hFFFF_FFFF, 4'hF, 1'b1); get_b(0);
    check("oor_bresp", 64'(cap_b), 64'd2);
    send_aw(4'd2, BASE + 32'h40, 4'd0, 2'b01, 3'b001); send_w(4'd2, 32'hFFFF_FFFF, 4'hF, 1'b1); get_b(0);
    check("size_bresp", 64'(cap_b), 64'd2);
    send_aw(4'd6, BASE + 32'h40, 4'd0, 2'b01, 3'b010); send_w(4'd9, 32'hFFFF_FFFF, 4'hF, 1'b1); get_b(0);
    check("wid_bresp", 64'({cap_bid, cap_b}), 64'({4'd6, 2'b10}));
    send_aw(4'd4, BASE + 32'h20, 4'd1, 2'b01, 3'b010);
    send_w(4'd4, 32'hEEEE_0000, 4'hF, 1'b1); send_w(4'd4, 32'hEEEE_0001, 4'hF, 1'b0); get_b(0);
    check("wlast_bresp", 64'(cap_b), 64'd2);
    rd1(4'd0, BASE + 32'h40);
    check("err_mem_kept", 64'(cap_d[0]), 64'h0000_0000_11BB_33DD);
    send_ar(4'd1, BASE + 32'h20, 4'd1, 2'b01, 3'b010); rd_collect(2, 1'b0);
    check("wlast_mem_kept", 64'({cap_d[0], cap_d[1]}), {32'd1, 32'd2});

    // read errors: out of range above/below, and a burst running off the end
    send_ar(4'd10, BASE + 32'h4000, 4'd0, 2'b01, 3'b010); rd_collect(1, 1'b0);
    check("oor_read", 64'({cap_d[0], cap_r[0]}), 64'({32'd0, 2'b10}));
    send_ar(4'd10, BASE - 32'd4, 4'd0, 2'b01, 3'b010); rd_collect(1, 1'b0);
    check("below_read", 64'(cap_r[0]), 64'd2);
    wr1(4'd1, BASE + 32'h3FFC, 32'hCAFE_F00D, 4'hF);
    send_ar(4'd11, BASE + 32'h3FFC, 4'd1, 2'b01, 3'b010); rd_collect(2, 1'b0);
    check("edge_beat0", 64'({cap_d[0], cap_r[0]}), 64'({32'hCAFE_F00D, 2'b00}));
    check("edge_beat1", 64'({cap_d[1], cap_r[1], cap_l[1]}), 64'({32'd0, 2'b10, 1'b1}));

    // concurrent AW/AR to one word, bready held low
    fork
      begin send_aw(4'd7, BASE + 32'h10, 4'd0, 2'b01, 3'b010); send_w(4'd7, 32'h1234_5678, 4'hF, 1'b1); end
      begin send_ar(4'd8, BASE + 32'h10, 4'd0, 2'b01, 3'b010); rd_collect(1, 1'b0); end
    join
    check("conc_old_data", 64'({cap_id, cap_d[0]}), 64'({4'd8, 32'hDEAD_BEEF}));
    get_b(5);
    check("conc_bresp", 64'({cap_bid, cap_b}), 64'({4'd7, 2'b00}));
    rd1(4'd0, BASE + 32'h10);
    check("conc_new_data", 64'(cap_d[0]), 64'h0000_0000_1234_5678);

    // reset in the middle of an 8-beat read
    send_aw(4'd1, BASE + 32'h100, 4'd7, 2'b01, 3'b010);
    for (int k = 0; k < 8; k++) send_w(4'd1, 32'hA000_0000 + 32'(k), 4'hF, k == 7);
    get_b(0);
    send_ar(4'd2, BASE + 32'h100, 4'd7, 2'b01, 3'b010);
    rd_collect(2, 1'b0);
    check("pre_rst_beats", 64'({cap_d[0], cap_d[1]}), {32'hA000_0000, 32'hA000_0001});
    rst_n = 1'b0;
    exp_r.delete(); exp_b.delete(); w_active = 1'b0;
    #1;
    check("rst_mid_rvalid", 64'(rvalid_o), 64'd0);
    check("rst_mid_arready", 64'(arready_o), 64'd1);
    @(posedge clk); #1; rst_n = 1'b1;
    rd1(4'd3, BASE + 32'h108);
    check("post_rst_mem", 64'(cap_d[0]), 64'h0000_0000_A000_0002);
    rd1(4'd3, BASE + 32'h10);
    check("post_rst_mem2", 64'(cap_d[0]), 64'h0000_0000_1234_5678);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
